// File: rtl/mem_axi_arbiter.sv
// Two-port (instruction fetch / data) to AXI4-Lite manager bridge.
// Arbitrates between the ports, issues one AXI-Lite read or write per grant,
// and routes the response back to the port that issued it.
// Only one transaction is in flight at a time.
//
// Handshakes: the requester side is request/grant. A port holds req and its
// address/data until it sees gnt in the same cycle. On the AXI side a
// transfer happens on a rising edge where valid and ready are both high.
// Every valid driven here stays high, with its payload stable, until that
// transfer.
module mem_axi_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter bit DATA_PRIORITY = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    m_ar_valid_o,
  input  logic                    m_ar_ready_i,
  output logic [ADDR_WIDTH-1:0]   m_ar_addr_o,
  input  logic                    m_r_valid_i,
  output logic                    m_r_ready_o,
  input  logic [DATA_WIDTH-1:0]   m_r_data_i,
  output logic                    m_aw_valid_o,
  input  logic                    m_aw_ready_i,
  output logic [ADDR_WIDTH-1:0]   m_aw_addr_o,
  output logic                    m_w_valid_o,
  input  logic                    m_w_ready_i,
  output logic [DATA_WIDTH-1:0]   m_w_data_o,
  output logic [DATA_WIDTH/8-1:0] m_w_strb_o,
  input  logic                    m_b_valid_i,
  output logic                    m_b_ready_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic OWNER_INSTR = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_e;

  state_e                  state_q, state_d;
  // Last granted port; it also names the owner of the transaction in flight.
  logic                    last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [STRB_WIDTH-1:0]   be_q, be_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    instr_rvalid_q, instr_rvalid_d;
  logic                    data_rvalid_q, data_rvalid_d;
  logic [DATA_WIDTH-1:0]   instr_rdata_q, instr_rdata_d;
  logic [DATA_WIDTH-1:0]   data_rdata_q, data_rdata_d;

  logic grant_instr, grant_data;
  logic aw_hs, w_hs;

  assign aw_hs = m_aw_valid_o && m_aw_ready_i;
  assign w_hs  = m_w_valid_o && m_w_ready_i;

  // Arbitration: grant is combinational and only in IDLE. Gating with rst_i
  // keeps every output low while reset is applied.
  always_comb begin
    grant_instr = 1'b0;
    grant_data  = 1'b0;
    if (state_q == IDLE && !rst_i) begin
      if (instr_req_i && data_req_i) begin
        if (DATA_PRIORITY || last_grant_q == OWNER_INSTR) grant_data = 1'b1;
        else                                              grant_instr = 1'b1;
      end else if (data_req_i) begin
        grant_data = 1'b1;
      end else if (instr_req_i) begin
        grant_instr = 1'b1;
      end
    end
  end

  // Next-state logic: capture the granted request, step the AXI phases, and
  // register the response for the owning port.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    addr_d         = addr_q;
    be_d           = be_q;
    wdata_d        = wdata_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    instr_rvalid_d = 1'b0;
    data_rvalid_d  = 1'b0;
    instr_rdata_d  = instr_rdata_q;
    data_rdata_d   = data_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_instr) begin
          // Fetches are always full-word reads.
          last_grant_d = OWNER_INSTR;
          addr_d       = instr_addr_i;
          be_d         = '1;
          wdata_d      = '0;
          state_d      = RD_ADDR;
        end else if (grant_data) begin
          last_grant_d = OWNER_DATA;
          addr_d       = data_addr_i;
          be_d         = data_be_i;
          wdata_d      = data_wdata_i;
          state_d      = data_we_i ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (m_ar_ready_i) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (m_r_valid_i) begin
          if (last_grant_q == OWNER_DATA) begin
            data_rdata_d  = m_r_data_i;
            data_rvalid_d = 1'b1;
          end else begin
            instr_rdata_d  = m_r_data_i;
            instr_rvalid_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      WR_REQ: begin
        // AW and W complete independently, in either order or together.
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_b_valid_i) begin
          data_rdata_d  = '0;
          data_rvalid_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      last_grant_q   <= OWNER_INSTR;
      addr_q         <= '0;
      be_q           <= '0;
      wdata_q        <= '0;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      instr_rvalid_q <= 1'b0;
      data_rvalid_q  <= 1'b0;
      instr_rdata_q  <= '0;
      data_rdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      addr_q         <= addr_d;
      be_q           <= be_d;
      wdata_q        <= wdata_d;
      aw_done_q      <= aw_done_d;
      w_done_q       <= w_done_d;
      instr_rvalid_q <= instr_rvalid_d;
      data_rvalid_q  <= data_rvalid_d;
      instr_rdata_q  <= instr_rdata_d;
      data_rdata_q   <= data_rdata_d;
    end
  end

  assign instr_gnt_o    = grant_instr;
  assign data_gnt_o     = grant_data;
  assign instr_rvalid_o = instr_rvalid_q;
  assign instr_rdata_o  = instr_rdata_q;
  assign data_rvalid_o  = data_rvalid_q;
  assign data_rdata_o   = data_rdata_q;

  assign m_ar_valid_o = (state_q == RD_ADDR);
  assign m_ar_addr_o  = addr_q;
  assign m_r_ready_o  = (state_q == RD_DATA);
  assign m_aw_valid_o = (state_q == WR_REQ) && !aw_done_q;
  assign m_aw_addr_o  = addr_q;
  assign m_w_valid_o  = (state_q == WR_REQ) && !w_done_q;
  assign m_w_data_o   = wdata_q;
  assign m_w_strb_o   = be_q;
  assign m_b_ready_o  = (state_q == WR_RESP);

endmodule
